weight_uart_tx: RTL and testbench

Serial read-out engine for the trained weight memory. On a one-cycle request it walks every row of the weights RAM, latches each row of `CLASSES` signed 8-bit weights, and streams a framed byte sequence out a UART TX pin (8N1, LSB first): a header, all weights row-major, then a checksum. It sits beside `network` at the top level. It is the reader counterpart to the update path that writes `weights_ram`, and it takes over the RAM address bus while `bus_req` is high.

---
 rtl/nn_pkg.sv | 12 +
 rtl/uart_tx_byte.sv | 56 +++++
 rtl/weight_uart_tx.sv | 157 +++++++++++++++
 tb/tb_weight_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the weight memory, its update path and the serial dump engine.
// Holds only types and constants; there is no logic, latency or backpressure here.
package nn_pkg;

  localparam int NN_CLASSES = 10;
  localparam logic [7:0] UART_HDR = 8'hA5;

  typedef logic [NN_CLASSES-1:0][7:0] weight_row_t;

  typedef enum logic [2:0] {IDLE, HDR, FETCH, ROW, SUM} dump_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer, LSB first; the start bit begins on the clock after accept.
// Backpressure via valid/ready: ready is high when idle and in the last stop-bit clock, so bytes chain gaplessly.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             active;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       shreg;
  logic             bit_end;

  assign bit_end  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tx_ready = !active || (bit_end && (bit_idx == 4'd9));

  // shreg holds the data bits still to send followed by the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      txd     <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= {1'b1, tx_data};
      txd     <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        bit_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          txd     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/weight_uart_tx.sv
// Dumps the weights RAM over UART as header, row-major weights, then a modulo-256 checksum.
// Header start bit follows the request by one clock; rows are separated by RD_LAT+1 idle clocks; requests while busy are dropped.
module weight_uart_tx
  import nn_pkg::*;
#(
  parameter int         CLASSES      = 10,
  parameter int         ROWS         = 256,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         RD_LAT       = 1,
  parameter logic [7:0] HDR_BYTE     = UART_HDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dump_start,
  input  logic [CLASSES-1:0][7:0] weights,
  output logic [7:0]              wram_addr,
  output logic                    bus_req,
  output logic                    busy,
  output logic                    done,
  output logic                    uart_txd
);

  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IDX_W  = $clog2(CLASSES + 1);
  localparam int FCNT_W = $clog2(RD_LAT + 1);

  dump_state_t             state, state_nxt;
  logic [ROW_W-1:0]        row, fetch_row;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              checksum;
  logic [CLASSES-1:0][7:0] row_buf;
  logic                    byte_sent;
  logic [FCNT_W-1:0]       fetch_cnt;

  logic       tx_valid, tx_ready, accept;
  logic [7:0] tx_data, buf_byte;
  logic       last_row, fetch_ready, row_drained;
  logic       start, enter_fetch, finish;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .txd      (uart_txd)
  );

  assign busy    = (state != IDLE);
  assign bus_req = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    buf_byte  = 8'h00;
    for (int i = 0; i < CLASSES; i++) begin
      if (idx == IDX_W'(i)) buf_byte = row_buf[i];
    end
    last_row    = (row == ROW_W'(ROWS - 1));
    fetch_ready = (fetch_cnt == FCNT_W'(RD_LAT));
    row_drained = (idx == IDX_W'(CLASSES));
    fetch_row   = (state == ROW) ? row + ROW_W'(1) : row;

    case (state)
      IDLE: begin
        // a request coinciding with the done pulse belongs to the finished frame
        if (dump_start && !done) state_nxt = HDR;
      end
      HDR: begin
        if (!byte_sent) begin
          tx_valid = 1'b1;
          tx_data  = HDR_BYTE;
        end else if (tx_ready) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // first byte of the row goes straight from the RAM so the gap is exactly RD_LAT+1
        if (fetch_ready) begin
          tx_valid = 1'b1;
          tx_data  = weights[0];
          if (tx_ready) state_nxt = ROW;
        end
      end
      ROW: begin
        if (!row_drained) begin
          tx_valid = 1'b1;
          tx_data  = buf_byte;
        end else if (last_row) begin
          state_nxt = SUM;
        end else if (tx_ready) begin
          state_nxt = FETCH;
        end
      end
      SUM: begin
        if (!byte_sent) begin
          tx_valid = 1'b1;
          tx_data  = checksum;
        end else if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    accept      = tx_valid && tx_ready;
    start       = (state == IDLE) && (state_nxt == HDR);
    enter_fetch = (state != FETCH) && (state_nxt == FETCH);
    finish      = (state == SUM) && byte_sent && tx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      idx       <= '0;
      checksum  <= '0;
      row_buf   <= '0;
      byte_sent <= 1'b0;
      fetch_cnt <= '0;
      wram_addr <= '0;
      done      <= 1'b0;
    end else begin
      done      <= finish;
      byte_sent <= (state_nxt != state) ? 1'b0 : (byte_sent | accept);

      if (start) begin
        checksum <= '0;
        row      <= '0;
      end

      if (enter_fetch) begin
        row       <= fetch_row;
        wram_addr <= 8'(fetch_row);
        fetch_cnt <= '0;
      end else if ((state == FETCH) && !fetch_ready) begin
        fetch_cnt <= fetch_cnt + FCNT_W'(1);
      end

      if (accept && ((state == FETCH) || (state == ROW)))
        checksum <= checksum + tx_data;

      if (accept && (state == FETCH)) begin
        row_buf <= weights;
        idx     <= IDX_W'(1);
      end else if (accept && (state == ROW)) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_weight_uart_tx.sv
// Bench for weight_uart_tx: frames are predicted from the RAM contents and compared bit-for-bit on the line.
// Two instances share the clock and reset: RD_LAT=1 (main) and RD_LAT=3.
module tb_weight_uart_tx;

  localparam int CPB     = 4;
  localparam int ROWS    = 2;
  localparam int CLASSES = 2;
  localparam int TAIL    = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ds1 = 1'b0, ds3 = 1'b0;
  logic [CLASSES-1:0][7:0] w1, w3;
  logic [7:0] addr1, addr3;
  logic bus1, bus3, busy1, busy3, done1, done3, txd1, txd3;

  logic [CLASSES-1:0][7:0] mem [256];
  logic [CLASSES-1:0][7:0] p3 [3];

  int vectors = 0;
  int miscompares = 0;

  logic sel = 1'b0;
  logic obs_txd, obs_busy, obs_bus, obs_done;
  logic [7:0] obs_addr;

  assign obs_txd  = sel ? txd3  : txd1;
  assign obs_busy = sel ? busy3 : busy1;
  assign obs_bus  = sel ? bus3  : bus1;
  assign obs_done = sel ? done3 : done1;
  assign obs_addr = sel ? addr3 : addr1;

  always #5 clk = ~clk;

  // RAM models: registered read, RD_LAT stages
  always @(posedge clk) w1 <= mem[addr1];
  always @(posedge clk) begin
    p3[0] <= mem[addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign w3 = p3[2];

  weight_uart_tx #(.CLASSES(CLASSES), .ROWS(ROWS), .CLKS_PER_BIT(CPB), .RD_LAT(1), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .dump_start(ds1), .weights(w1), .wram_addr(addr1),
    .bus_req(bus1), .busy(busy1), .done(done1), .uart_txd(txd1));

  weight_uart_tx #(.CLASSES(CLASSES), .ROWS(ROWS), .CLKS_PER_BIT(CPB), .RD_LAT(3), .HDR_BYTE(8'hA5)) dut3 (
    .clk(clk), .rst_n(rst_n), .dump_start(ds3), .weights(w3), .wram_addr(addr3),
    .bus_req(bus3), .busy(busy3), .done(done3), .uart_txd(txd3));

  // reference frame
  logic [7:0] exp_bytes[$];
  int         exp_start[$];
  int         exp_fetch[$];
  logic       exp_wave[$];
  int         exp_done;

  logic       cap_txd[$];
  logic [7:0] cap_addr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_ds(input bit use3, input logic v);
    if (use3) ds3 = v;
    else      ds1 = v;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_start.push_back(exp_wave.size() + 1);
    exp_bytes.push_back(b);
    for (int j = 0; j < 10; j++) begin
      logic bv;
      bv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      repeat (CPB) exp_wave.push_back(bv);
    end
  endtask

  task automatic build_model(input int lat);
    logic [7:0] sum;
    exp_bytes.delete(); exp_start.delete(); exp_fetch.delete(); exp_wave.delete();
    sum = 8'h00;
    push_byte(8'hA5);
    for (int r = 0; r < ROWS; r++) begin
      exp_fetch.push_back(exp_wave.size() + 1 + lat);
      repeat (lat + 1) exp_wave.push_back(1'b1);
      for (int k = 0; k < CLASSES; k++) begin
        push_byte(mem[r][k]);
        sum = sum + mem[r][k];
      end
    end
    push_byte(sum);
    exp_done = exp_wave.size() + 1;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < CLASSES; k++) mem[r][k] = 8'($urandom);
  endtask

  task automatic fill_const(input logic [7:0] b);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < CLASSES; k++) mem[r][k] = b;
  endtask

  // poke > 0: pulse dump_start so it is sampled in cycle poke+1; poke < 0: during the done cycle
  task automatic run_dump(input bit use3, input int poke_in);
    int poke, own_err, done_cnt, first_done, werr;
    build_model(use3 ? 3 : 1);
    poke = (poke_in < 0) ? exp_done : poke_in;
    sel = use3;
    own_err = 0; done_cnt = 0; first_done = 0; werr = 0;
    cap_txd.delete(); cap_addr.delete();
    @(negedge clk); set_ds(use3, 1'b1);
    @(negedge clk); set_ds(use3, 1'b0);
    if (obs_busy !== 1'b1 || obs_bus !== obs_busy) own_err++;
    for (int c = 1; c <= exp_done + TAIL; c++) begin
      @(negedge clk);
      if (c == poke + 1) set_ds(use3, 1'b0);
      cap_txd.push_back(obs_txd);
      cap_addr.push_back(obs_addr);
      if (obs_done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (obs_busy !== (c < exp_done) || obs_bus !== obs_busy) own_err++;
      if (c == poke) set_ds(use3, 1'b1);
    end
    check("done_cycle", first_done, exp_done);
    check("done_count", done_cnt, 1);
    check("busy_bus_req", own_err, 0);
    for (int i = 0; i < cap_txd.size(); i++) begin
      if (i < exp_wave.size()) begin
        if (cap_txd[i] !== exp_wave[i]) werr++;
      end else if (cap_txd[i] !== 1'b1) werr++;
    end
    check("line_wave", werr, 0);
    for (int b = 0; b < exp_bytes.size(); b++) begin
      logic [7:0] dec;
      for (int i = 0; i < 8; i++) dec[i] = cap_txd[exp_start[b] + CPB*(i+1) + CPB/2 - 1];
      check($sformatf("byte%0d", b), {24'd0, dec}, {24'd0, exp_bytes[b]});
    end
    for (int r = 0; r < ROWS; r++)
      check($sformatf("addr_row%0d", r), {24'd0, cap_addr[exp_fetch[r] - 1]}, r);
  endtask

  initial begin
    int dcnt;
    fill_const(8'h00);
    repeat (3) @(negedge clk);
    check("rst_txd", txd1, 1);
    check("rst_busy", busy1, 0);
    check("rst_bus_req", bus1, 0);
    check("rst_done", done1, 0);
    check("rst_addr", addr1, 0);
    check("rst_txd3", txd3, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame A5 01 02 FF 10 12
    mem[0] = {8'h02, 8'h01};
    mem[1] = {8'h10, 8'hFF};
    run_dump(1'b0, 0);

    // checksum wrap cases, second one with a request during the done pulse
    fill_const(8'h80);
    run_dump(1'b0, 0);
    fill_const(8'hFF);
    run_dump(1'b0, -1);

    // random data, request while busy in row 0
    fill_rand();
    run_dump(1'b0, 60);
    fill_rand();
    run_dump(1'b0, 0);

    // async reset during d0 of the first row byte
    fill_rand();
    sel = 1'b0;
    @(negedge clk); ds1 = 1'b1;
    @(negedge clk); ds1 = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", txd1, 1);
    check("midrst_busy", busy1, 0);
    check("midrst_bus_req", bus1, 0);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || txd1 !== 1'b1) dcnt++;
    end
    check("midrst_quiet", dcnt, 0);
    check("midrst_addr", addr1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_dump(1'b0, 0);

    // longer read latency
    fill_rand();
    run_dump(1'b1, 0);
    fill_rand();
    run_dump(1'b1, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
